// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Bridges a simple CPU bus to an external byte RAM and a small block of
//   memory-mapped IO: a UART transmit FIFO, an optional UART receive port,
//   a free-running 32-bit cycle counter with a snapshot register, and a
//   sticky program-end flag.
//
//   Address map (only cpu_a[17:0] is decoded; cpu_a[17:16]==2'b11 is IO):
//     0x30000  W: push byte into tx FIFO (zero byte ignored)
//              R: rx byte and one-cycle ack if rx valid, else 0x00
//     0x30004  W: set prog_stop and push 0x00 into tx FIFO
//              R: counter[7:0], and latch the counter into the snapshot
//     0x30005-0x30007  R: snapshot bytes 1..3
//     any other IO address: reads 0x00, writes ignored
//
//   Optional feature: define MEM_IO_UART_RX_EN to build the rx path.
//   Without it, 0x30000 reads 0x00 and uart_rx_ack is tied low.
//
//   Parameters
//     TX_DEPTH_LOG2  tx FIFO depth is 2**TX_DEPTH_LOG2 entries (>= 2)
//   Ports
//     clk_in, rst_in            clock, synchronous active-high reset
//     rdy_in                    CPU enable; low freezes CPU-facing state
//     cpu_a/cpu_dout/cpu_wr     CPU address, write data, write strobe
//     cpu_din                   read data, one cycle after the address
//     io_buffer_full            tx FIFO count >= depth-2
//     ram_a/ram_din/ram_we      RAM address, write data, write enable
//     ram_dout                  RAM read data, one cycle after ram_a
//     uart_tx_*                 tx byte stream out of the FIFO
//     uart_rx_*                 rx byte stream in
//     prog_stop                 sticky program-end flag
//
//   Handshakes: a tx byte transfers on a rising edge where uart_tx_valid
//   and uart_tx_ready are both high; uart_tx_valid never depends on
//   uart_tx_ready. An rx byte is consumed on a rising edge where
//   uart_rx_ack is high; ack is only raised while uart_rx_valid is high.
module mem_io_bridge #(
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack,
  output logic        prog_stop
);

  typedef logic [TX_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [TX_DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t        C_DEPTH     = cnt_t'(1 << TX_DEPTH_LOG2);
  localparam cnt_t        C_FULL_THR  = cnt_t'((1 << TX_DEPTH_LOG2) - 2);
  localparam logic [17:0] C_ADDR_UART = 18'h30000;
  localparam logic [17:0] C_ADDR_CNT  = 18'h30004;
  localparam logic [17:0] C_ADDR_SN1  = 18'h30005;
  localparam logic [17:0] C_ADDR_SN2  = 18'h30006;
  localparam logic [17:0] C_ADDR_SN3  = 18'h30007;

  // tx FIFO storage and bookkeeping
  logic [7:0]  r_mem [0:(1 << TX_DEPTH_LOG2)-1];
  ptr_t        r_wr_ptr;
  ptr_t        r_rd_ptr;
  cnt_t        r_count;

  logic [31:0] r_cnt;
  // Byte 0 of the snapshot is never read back (0x30004 returns the live
  // counter), so only counter bits 31:8 are held.
  logic [23:0] r_snap;
  logic        r_prog_stop;
  logic        r_sel_io;
  logic [7:0]  r_io_byte;

  logic [17:0] w_addr;
  logic        w_is_io;
  logic        w_io_rd;
  logic        w_io_wr;
  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_full;
  logic        w_snap_take;
  logic [7:0]  w_push_data;
  logic [7:0]  w_rd_byte;
  logic        w_unused;

  assign w_addr  = cpu_a[17:0];
  assign w_is_io = (w_addr[17:16] == 2'b11);
  assign w_io_rd = rdy_in & ~cpu_wr & w_is_io;
  assign w_io_wr = rdy_in &  cpu_wr & w_is_io;

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_we  = rdy_in & cpu_wr & ~w_is_io;

  // The stop write doubles as an end-of-output marker in the tx stream.
  assign w_push      = w_io_wr & (((w_addr == C_ADDR_UART) & (cpu_dout != 8'h00)) |
                                  (w_addr == C_ADDR_CNT));
  assign w_push_data = (w_addr == C_ADDR_CNT) ? 8'h00 : cpu_dout;
  assign w_full      = (r_count == C_DEPTH);
  assign w_pop       = (r_count != '0) & uart_tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_snap_take = w_io_rd & (w_addr == C_ADDR_CNT);

`ifdef MEM_IO_UART_RX_EN
  logic w_rx_take;
  assign w_rx_take   = w_io_rd & (w_addr == C_ADDR_UART) & uart_rx_valid;
  assign uart_rx_ack = w_rx_take & ~rst_in;
  assign w_unused    = ^cpu_a[31:18];
`else
  assign uart_rx_ack = 1'b0;
  assign w_unused    = ^{cpu_a[31:18], uart_rx_data, uart_rx_valid};
`endif

  // IO read byte, captured at the edge so it lines up with RAM latency.
  always_comb begin
    w_rd_byte = 8'h00;
    case (w_addr)
`ifdef MEM_IO_UART_RX_EN
      C_ADDR_UART: if (w_rx_take) w_rd_byte = uart_rx_data;
`endif
      C_ADDR_CNT:  w_rd_byte = r_cnt[7:0];
      C_ADDR_SN1:  w_rd_byte = r_snap[7:0];
      C_ADDR_SN2:  w_rd_byte = r_snap[15:8];
      C_ADDR_SN3:  w_rd_byte = r_snap[23:16];
      default:     w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_snap      <= '0;
      r_prog_stop <= 1'b0;
      r_sel_io    <= 1'b0;
      r_io_byte   <= 8'h00;
    end else begin
      // FIFO drains regardless of rdy_in; pushes are already gated by it.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
      if (rdy_in) begin
        r_cnt     <= r_cnt + 32'd1;
        r_sel_io  <= w_is_io;
        r_io_byte <= w_rd_byte;
      end
      // Snapshot takes the pre-increment value so bytes 1..3 match the
      // byte 0 returned on the same read.
      if (w_snap_take) r_snap <= r_cnt[31:8];
      if (w_io_wr && (w_addr == C_ADDR_CNT)) r_prog_stop <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push_ok && !rst_in) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign uart_tx_data   = r_mem[r_rd_ptr];
  assign uart_tx_valid  = (r_count != '0) & ~rst_in;
  assign io_buffer_full = (r_count >= C_FULL_THR) & ~rst_in;
  assign prog_stop      = r_prog_stop & ~rst_in;
  assign cpu_din        = rst_in ? 8'h00 : (r_sel_io ? r_io_byte : ram_dout);

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ack;
  logic        prog_stop;

  mem_io_bridge #(.TX_DEPTH_LOG2(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ack(uart_rx_ack), .prog_stop(prog_stop)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_err    = 0;
  int n_emit   = 0;
  int n_drop   = 0;

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  env_ram [logic [16:0]];
  logic [7:0]  m_ram   [logic [16:0]];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_stop;
  logic [7:0]  exp_din;
  logic        din_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] env_rd(input logic [16:0] addr);
    return env_ram.exists(addr) ? env_ram[addr] : 8'h00;
  endfunction

  function automatic logic [7:0] m_ram_rd(input logic [16:0] addr);
    return m_ram.exists(addr) ? m_ram[addr] : 8'h00;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else n_drop++;
  endfunction

  // One bus cycle: drive, check combinational outputs, advance the model
  // across the edge, then check registered outputs at the falling edge.
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rdy, input logic txr);
    logic [17:0] off;
    logic        is_io;
    logic        pop;
    logic        rx_take;
    logic [7:0]  rd_byte;
    logic [16:0] ra;
    logic        we;
    logic [7:0]  wd;
    cpu_a = a; cpu_wr = wr; cpu_dout = d; rdy_in = rdy; uart_tx_ready = txr;
    #1;
    off     = a[17:0];
    is_io   = (off >= 18'h30000);
    rx_take = 1'b0;
`ifdef MEM_IO_UART_RX_EN
    rx_take = rdy && !wr && (off == 18'h30000) && uart_rx_valid;
`endif
    check("ram_we", ram_we, rdy && wr && !is_io);
    check("ram_a", ram_a, a[16:0]);
    check("rx_ack", uart_rx_ack, rx_take);
    pop = (exp_q.size() != 0) && txr;
    if (pop) begin
      check("tx_data", uart_tx_data, exp_q[0]);
      n_emit++;
    end
    rd_byte = 8'h00;
    if (!is_io) rd_byte = m_ram_rd(a[16:0]);
    else if (off == 18'h30000) rd_byte = rx_take ? uart_rx_data : 8'h00;
    else if (off == 18'h30004) rd_byte = m_cnt[7:0];
    else if (off >= 18'h30005 && off <= 18'h30007)
      rd_byte = 8'(m_snap >> (8 * (off - 18'h30004)));
    ra = ram_a; we = ram_we; wd = ram_din;
    @(posedge clk_in);
    ram_dout = env_rd(ra);
    if (we) env_ram[ra] = wd;
    if (pop) void'(exp_q.pop_front());
    if (rdy) begin
      if (wr && !is_io) m_ram[a[16:0]] = d;
      if (wr && off == 18'h30000 && d != 8'h00) m_push(d);
      if (wr && off == 18'h30004) begin
        m_stop = 1'b1;
        m_push(8'h00);
      end
      if (!wr && off == 18'h30004) m_snap = m_cnt;
      m_cnt     = m_cnt + 32'd1;
      exp_din   = rd_byte;
      din_known = !wr;
    end else begin
      din_known = 1'b0;
    end
    @(negedge clk_in);
    if (din_known) check("cpu_din", cpu_din, exp_din);
    check("tx_valid", uart_tx_valid, exp_q.size() != 0);
    check("buf_full", io_buffer_full, exp_q.size() >= DEPTH - 2);
    check("prog_stop", prog_stop, m_stop);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 8'h00, 1'b1, txr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_in = 1'b1; rdy_in = 1'b1; cpu_a = 32'h30000; cpu_wr = 1'b0;
      cpu_dout = 8'h00; uart_tx_ready = 1'b1;
      uart_rx_valid = 1'b1; uart_rx_data = 8'h5C; ram_dout = 8'hA5;
      #1;
      check("rst_cpu_din", cpu_din, 8'h00);
      check("rst_tx_valid", uart_tx_valid, 1'b0);
      check("rst_rx_ack", uart_rx_ack, 1'b0);
      check("rst_buf_full", io_buffer_full, 1'b0);
      check("rst_prog_stop", prog_stop, 1'b0);
      @(posedge clk_in);
      @(negedge clk_in);
    end
    rst_in = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00; ram_dout = 8'h00;
    exp_q.delete();
    m_cnt = '0; m_snap = '0; m_stop = 1'b0; din_known = 1'b0;
  endtask

  initial begin
    int e0;
    int d0;
    logic [7:0] x;
    do_reset(3);

    // single byte out, then empty
    step(32'h30000, 1'b1, 8'h41, 1'b1, 1'b1);
    check("tx_valid_41", uart_tx_valid, 1'b1);
    check("tx_data_41", uart_tx_data, 8'h41);
    idle(1, 1'b1);
    check("tx_empty_41", uart_tx_valid, 1'b0);

    // zero byte ignored; stop write emits 0x00
    step(32'h30000, 1'b1, 8'h00, 1'b1, 1'b1);
    check("zero_no_push", uart_tx_valid, 1'b0);
    step(32'h30004, 1'b1, 8'h99, 1'b1, 1'b0);
    check("stop_set", prog_stop, 1'b1);
    check("stop_byte", uart_tx_data, 8'h00);
    idle(2, 1'b1);

    // fill to full with ready low, overflow drop, then ordered drain
    d0 = n_drop;
    for (int i = 1; i <= 9; i++) begin
      step(32'h30000, 1'b1, 8'(i), 1'b1, 1'b0);
      if (i == 5) check("full_after5", io_buffer_full, 1'b0);
      if (i == 6) check("full_after6", io_buffer_full, 1'b1);
    end
    check("drop_count", n_drop - d0, 1);
    e0 = n_emit;
    idle(12, 1'b1);
    check("emit_count", n_emit - e0, 8);

    // full FIFO with simultaneous push and pop accepts both
    for (int i = 0; i < 8; i++) step(32'h30000, 1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
    e0 = n_emit;
    step(32'h30000, 1'b1, 8'hEE, 1'b1, 1'b1);
    idle(12, 1'b1);
    check("pushpop_emit", n_emit - e0, 9);

    // RAM write then read
    step(32'h00123, 1'b1, 8'h5A, 1'b1, 1'b1);
    step(32'h00123, 1'b0, 8'h00, 1'b1, 1'b1);
    check("ram_rd_5a", cpu_din, 8'h5A);

    // unmapped IO
    step(32'h3000C, 1'b1, 8'h12, 1'b1, 1'b1);
    step(32'h30008, 1'b0, 8'h00, 1'b1, 1'b1);
    check("unmapped_rd", cpu_din, 8'h00);

    // counter snapshot coherence around 0xFF -> 0x100
    do_reset(2);
    while (m_cnt != 32'hFF) idle(1, 1'b1);
    step(32'h30004, 1'b0, 8'h00, 1'b1, 1'b1);
    check("snap_b0", cpu_din, 8'hFF);
    step(32'h30005, 1'b0, 8'h00, 1'b1, 1'b1);
    check("snap_b1", cpu_din, 8'h00);
    step(32'h30006, 1'b0, 8'h00, 1'b1, 1'b1);
    check("snap_b2", cpu_din, 8'h00);
    step(32'h30007, 1'b0, 8'h00, 1'b1, 1'b1);
    check("snap_b3", cpu_din, 8'h00);

    // rdy_in low: counter frozen, CPU writes ignored, FIFO still drains
    for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    x = m_cnt[7:0];
    step(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0);
    e0 = n_emit;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(32'h30000, 1'b1, 8'h77, 1'b0, 1'b1);
      else            step(32'h30004, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    check("stall_drain", n_emit - e0, 3);
    step(32'h30004, 1'b0, 8'h00, 1'b1, 1'b1);
    check("stall_cnt", cpu_din, 8'(x + 8'd1));

    // rx read
    uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
    step(32'h30000, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef MEM_IO_UART_RX_EN
    check("rx_byte", cpu_din, 8'h33);
`else
    check("rx_disabled", cpu_din, 8'h00);
`endif
    uart_rx_valid = 1'b0;
    idle(1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [31:0] a;
      logic [7:0]  d;
      sel = $urandom_range(0, 9);
      a = $urandom();
      case (sel)
        0, 1, 2: a[17:0] = 18'($urandom_range(0, 15));
        3:       a[17:0] = 18'h2FFF0 + 18'($urandom_range(0, 15));
        4, 5, 8: a[17:0] = 18'h30000;
        6, 9:    a[17:0] = 18'h30004 + 18'($urandom_range(0, 3));
        default: a[17:0] = ($urandom_range(0, 1) == 0) ?
                           18'h30000 + 18'($urandom_range(1, 3)) :
                           18'h30008 + 18'($urandom_range(0, 32'hFFF7));
      endcase
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_rx_data  = 8'($urandom_range(0, 255));
      step(a, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 1)));
    end
    uart_rx_valid = 1'b0;

    // reset mid-drain discards queued bytes
    idle(12, 1'b1);
    for (int i = 0; i < 5; i++) step(32'h30000, 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
    e0 = n_emit;
    do_reset(2);
    idle(4, 1'b1);
    check("rst_discard", n_emit - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH_LOG2, default 3: UART tx FIFO depth is 2**TX_DEPTH_LOG2 entries.
REQ-002 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rdy_in  input  1  CPU-side enable; low freezes all CPU-facing state.
REQ-005 SHALL have port cpu_a  input  32  CPU address; only bits 17:0 are decoded.
REQ-006 SHALL have port cpu_dout  input  8  write data from the CPU.
REQ-007 SHALL have port cpu_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cpu_din  output  8  read data to the CPU.
REQ-009 SHALL have port io_buffer_full  output  1  tx FIFO near-full indication to the CPU.
REQ-010 SHALL have ports ram_a  output  17, ram_din  output  8, ram_we  output  1, ram_dout  input  8; the RAM returns read data one cycle after the address.
REQ-011 SHALL have ports uart_tx_data  output  8, uart_tx_valid  output  1, uart_tx_ready  input  1.
REQ-012 SHALL have ports uart_rx_data  input  8, uart_rx_valid  input  1, uart_rx_ack  output  1.
REQ-013 SHALL have port prog_stop  output  1  sticky program-end flag.

Function
REQ-014 SHALL treat an access as IO when cpu_a[17:16]==2'b11, and as RAM otherwise.
REQ-015 SHALL drive ram_a=cpu_a[16:0] and ram_din=cpu_dout combinationally, and ram_we=cpu_wr & RAM & rdy_in.
REQ-016 SHALL return read data exactly 1 cycle after the address: a registered select (RAM/IO) plus registered IO byte, with cpu_din=ram_dout when the select is RAM.
REQ-017 SHALL, on an IO write to 0x30000 with a nonzero byte, push the byte into the tx FIFO; a zero byte is ignored.
REQ-018 SHALL, on an IO write to 0x30004, set prog_stop and push 0x00 into the tx FIFO.
REQ-019 SHALL, on an IO read of 0x30000, return uart_rx_data if uart_rx_valid and pulse uart_rx_ack for 1 cycle; otherwise it returns 0x00 with no ack.
REQ-020 SHALL have a 32-bit cycle counter that increments each cycle rdy_in=1 and wraps at 2**32.
REQ-021 SHALL, on a read of 0x30004, return counter[7:0] and latch the counter into a snapshot register; reads of 0x30005-0x30007 return snapshot bytes 1-3.
REQ-022 SHALL pop the FIFO head when uart_tx_valid & uart_tx_ready; uart_tx_valid = FIFO non-empty, and uart_tx_data = head entry (registered).
REQ-023 SHALL drain the FIFO independently of rdy_in.
REQ-024 SHALL assert io_buffer_full when count >= depth-2, giving margin for in-flight CPU writes.
REQ-025 SHALL, on a push to a full FIFO without a simultaneous pop, drop the byte; when full with a simultaneous push and pop, accept both.
REQ-026 SHALL, on a push to an empty FIFO, make the data visible on uart_tx_valid the next cycle.
REQ-027 SHALL make no CPU-side state change while rdy_in=0: no push, no counter increment, no snapshot, and no rx ack.
REQ-028 SHALL return 0x00 for an IO read of any unmapped IO address, and SHALL ignore an IO write to any unmapped IO address.

Reset
REQ-029 SHALL, when rst_in=1 at a clock edge, clear the FIFO (pointers and count = 0), the counter, the snapshot, prog_stop and the read select.
REQ-030 SHALL hold cpu_din=0x00, uart_tx_valid=0, uart_rx_ack=0, io_buffer_full=0 and prog_stop=0 during reset.
REQ-031 SHALL, when reset occurs mid-drain, discard queued bytes without emitting them.

Configuration
REQ-032 SHALL compile the rx path only when macro MEM_IO_UART_RX_EN is defined; with the macro, REQ-019 applies; without it, a read of 0x30000 returns 0x00, uart_rx_ack is tied 0 and uart_rx_* are unused.

Verification
REQ-033 SHALL cover: write 0x41 to 0x30000 with uart_tx_ready=1 -> uart_tx_valid=1 with data 0x41 on the following cycle, then the FIFO is empty.
REQ-034 SHALL cover: write 0x00 to 0x30000 -> no push; write any byte to 0x30004 -> prog_stop=1 and 0x00 is emitted.
REQ-035 SHALL cover: with TX_DEPTH_LOG2=3 and uart_tx_ready=0, 8 writes -> io_buffer_full=1 after the 6th; the 9th is dropped; releasing ready emits exactly 8 bytes in order.
REQ-036 SHALL cover: RAM write 0x5A to 0x00123, then read 0x00123 -> cpu_din=0x5A one cycle later with ram_we=0 on the read.
REQ-037 SHALL cover: counter preloaded to 0x000000FF before reading 0x30004-0x30007 on consecutive cycles -> bytes FF,00,00,00 (the snapshot is coherent despite the increment).
REQ-038 SHALL cover: rdy_in=0 for 5 cycles -> counter unchanged while the FIFO still drains; with MEM_IO_UART_RX_EN, uart_rx_valid=1 with data 0x33 read at 0x30000 -> 0x33 and a 1-cycle uart_rx_ack.
